// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave word memory behind the AHB-to-APB bridge.
// Adds programmable wait states, an address-error response and saturating transfer counters.
// Ports:
//   Hclk, Hresetn           clock (rising edge) and asynchronous active-low reset
//   Pselx[2:0]              one-hot slave selects; only bit SEL_IDX is decoded
//   Penable, Pwrite         APB access-phase strobe and direction (1 = write)
//   Paddr[31:0], Pwdata     byte address and write data, sampled in the setup cycle only
//   Prdata, Pready, Pslverr read data, completion strobe and error response
//   wr_count, rd_count      completed good writes / reads (saturating)
//   err_count               error completions plus protocol aborts (saturating)
module apb_slave_mem #(
  parameter int unsigned SEL_IDX     = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        Hclk,
  input  logic        Hresetn,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [15:0] err_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // 33-bit upper bound so a window ending at 4 GiB does not wrap.
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [AW-1:0] r_idx;
  logic          r_wr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rd;
  logic          r_err;
  logic [3:0]    r_wcnt;
  logic [15:0]   r_wr_cnt;
  logic [15:0]   r_rd_cnt;
  logic [15:0]   r_err_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic          w_sel;
  logic          w_setup;
  logic          w_abort;
  logic          w_done;
  logic          w_err;
  logic [AW-1:0] w_idx;

  // Masking the whole vector keeps the unused select bits out of the logic cone.
  assign w_sel   = |(Pselx & (3'b001 << SEL_IDX));
  assign w_setup = (r_state == StIdle) & w_sel & ~Penable;
  assign w_abort = (r_state == StAccess) & ~(w_sel & Penable);
  assign w_done  = (r_state == StAccess) & w_sel & Penable & (r_wcnt == 4'd0);
  assign w_idx   = AW'((Paddr - BASE_ADDR) >> 2);
  assign w_err   = (Paddr < BASE_ADDR) | ({1'b0, Paddr} >= LIMIT) | (Paddr[1:0] != 2'b00);

  // State register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (w_setup) w_state_nxt = StAccess;
      StAccess: if (w_abort || w_done) w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // Outputs decode registers only, so Pready has no combinational input path.
  always_comb begin
    Pready  = (r_state == StAccess) && (r_wcnt == 4'd0);
    Pslverr = Pready & r_err;
    Prdata  = (Pready && !r_wr && !r_err) ? r_rd : 32'h0;
  end

  // Transfer latches, wait counter and statistics.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      r_idx     <= '0;
      r_wr      <= 1'b0;
      r_wdata   <= '0;
      r_rd      <= '0;
      r_err     <= 1'b0;
      r_wcnt    <= '0;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_setup) begin
        r_idx   <= w_idx;
        r_wr    <= Pwrite;
        r_wdata <= Pwdata;
        r_rd    <= r_mem[w_idx];
        r_err   <= w_err;
        r_wcnt  <= 4'(WAIT_STATES);
      end else if ((r_state == StAccess) && !w_abort && (r_wcnt != 4'd0)) begin
        r_wcnt <= r_wcnt - 4'd1;
      end

      if (w_done && r_wr && !r_err && (r_wr_cnt != 16'hFFFF)) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_done && !r_wr && !r_err && (r_rd_cnt != 16'hFFFF)) r_rd_cnt <= r_rd_cnt + 16'd1;
      if ((w_abort || (w_done && r_err)) && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  // Storage is deliberately not reset; reset forces IDLE so no commit can happen.
  always_ff @(posedge Hclk) begin
    if (w_done && r_wr && !r_err) r_mem[r_idx] <= r_wdata;
  end

  assign wr_count  = r_wr_cnt;
  assign rd_count  = r_rd_cnt;
  assign err_count = r_err_cnt;

endmodule
